// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter/rotator: one registered stage per shift-amount bit.
// Stage k shifts by 2^k when its amount bit is set.
// A stalled output freezes every stage, and flush clears every stage valid.
module shift_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_err
);

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHRA = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    logic stall;

    // Fixed-distance shift used by every stage. Illegal ops pass the data through untouched.
    function automatic logic [WIDTH-1:0] shift_fixed(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             sgn,
        input int               sh
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] fill;
        ones = '1;
        fill = sgn ? ~(ones >> sh) : '0;
        case (op)
            OP_SHL:  shift_fixed = d << sh;
            OP_SHR:  shift_fixed = d >> sh;
            OP_SHRA: shift_fixed = (d >> sh) | fill;
            OP_ROL:  shift_fixed = (d << sh) | (d >> (WIDTH - sh));
            OP_ROR:  shift_fixed = (d >> sh) | (d << (WIDTH - sh));
            default: shift_fixed = d;
        endcase
    endfunction

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int SH = 1 << k;
        // Amount bits still pending at this stage's input; bit 0 is this stage's enable.
        localparam int AW = SHW - k;

        logic [WIDTH-1:0] src_data;
        logic [AW-1:0]    src_amt;
        logic [2:0]       src_op;
        logic             src_sign;
        logic [TAGW-1:0]  src_tag;
        logic             src_err;
        logic             src_valid;
        logic [WIDTH-1:0] shifted;

        logic [WIDTH-1:0] data_q;
        logic [TAGW-1:0]  tag_q;
        logic             err_q;
        logic             valid_q;

        if (k == 0) begin : g_src
            assign src_data  = in_data;
            assign src_amt   = in_amt;
            assign src_op    = in_op;
            assign src_sign  = in_data[WIDTH-1];
            assign src_tag   = in_tag;
            assign src_err   = (in_op > OP_ROR);
            assign src_valid = in_valid;
        end else begin : g_src
            assign src_data  = g_stage[k-1].data_q;
            assign src_amt   = g_stage[k-1].g_ctl.amt_q;
            assign src_op    = g_stage[k-1].g_ctl.op_q;
            assign src_sign  = g_stage[k-1].g_ctl.sign_q;
            assign src_tag   = g_stage[k-1].tag_q;
            assign src_err   = g_stage[k-1].err_q;
            assign src_valid = g_stage[k-1].valid_q;
        end

        // Conditionally apply this stage's 2^k shift.
        always_comb begin
            shifted = src_amt[0] ? shift_fixed(src_data, src_op, src_sign, SH) : src_data;
        end

        // Stage payload and valid; flush clears the valid even while stalled.
        always_ff @(posedge clk or negedge clear_n) begin
            if (!clear_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                if (flush) begin
                    valid_q <= 1'b0;
                end else if (!stall) begin
                    valid_q <= src_valid;
                end
                if (!stall) begin
                    data_q <= shifted;
                    tag_q  <= src_tag;
                    err_q  <= src_err;
                end
            end
        end

        // The last stage needs no op, sign or remaining amount, so only earlier stages carry them.
        if (k < SHW - 1) begin : g_ctl
            logic [AW-2:0] amt_q;
            logic [2:0]    op_q;
            logic          sign_q;

            // Control fields travel with the data.
            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n) begin
                    amt_q  <= '0;
                    op_q   <= 3'd0;
                    sign_q <= 1'b0;
                end else if (!stall) begin
                    amt_q  <= src_amt[AW-1:1];
                    op_q   <= src_op;
                    sign_q <= src_sign;
                end
            end
        end
    end

    assign out_valid = g_stage[SHW-1].valid_q;
    assign out_data  = g_stage[SHW-1].data_q;
    assign out_tag   = g_stage[SHW-1].tag_q;
    assign out_err   = g_stage[SHW-1].err_q;

    // A held result freezes the whole pipe, bubbles included.
    always_comb begin
        stall    = out_valid && !out_ready;
        in_ready = !stall;
    end

endmodule
